dbus_responder: RTL and testbench
=================================

Name: dbus_responder

Overview:
Memory-side responder for the core's data bus. It accepts dbus_req_t requests and answers with dbus_resp_t after a configurable, optionally jittered latency. Backing store is an internal 64-bit-wide word array. It replaces the external memory model in block-level and core-level simulation, and it exercises the core's WAITING/OVER stall path.

Parameters:
- DEPTH, 1024, number of 64-bit words in the backing array; must be a power of 2.
- LATENCY, 2, base cycles from acceptance to data_ok; must be ≥1.
- RAND_LAT, 0, when 1 an LFSR adds 0..3 extra cycles per request.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- dreq  in  dbus_req_t  request: valid, addr[63:0], size, strobe[7:0], data[63:0].
- dresp  out  dbus_resp_t  response: addr_ok, data_ok, data[63:0].
- init_we  in  1  backdoor preload write enable.
- init_addr  in  64  backdoor byte address; word index taken from it.
- init_data  in  64  backdoor full-word write data.
- init_ready  out  1  backdoor write will be honoured this cycle.
- req_cnt  out  32  completed-request counter; wraps.

Behaviour:
- Word index: idx = addr[$clog2(DEPTH)+2:3]. Upper address bits are ignored, so addresses alias modulo DEPTH*8. addr[2:0] is ignored; byte lane selection is the initiator's job.
- Operation type: write if strobe != 0, otherwise read. size is latched but does not affect the array operation.
- Reset (reset low, asynchronous):
  - state=IDLE; addr_ok=0; data_ok=0; dresp.data=0; req_cnt=0; LFSR=LFSR_SEED.
  - Array contents are not reset and are retained.
  - A pending write is discarded.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - addr_ok = dreq.valid, combinational.
  - On dreq.valid: latch idx, strobe and data; load cnt = LATENCY-1 + extra; go to WAIT.
  - extra = LFSR[1:0] when RAND_LAT=1, else 0.
  - The LFSR advances one step on every acceptance (taps 16,14,13,11).
- WAIT:
  - addr_ok=0.
  - When cnt != 0, decrement cnt.
  - When cnt == 0, assert data_ok for exactly that one cycle.
    - Read: dresp.data = mem[idx] during that cycle, driven from a registered read.
    - Write: for each byte b where strobe[b]=1, mem[idx] byte b ← data byte b at the end of that cycle. dresp.data = the pre-write word.
    - req_cnt increments.
    - Go to DONE.
- Latency: data_ok rises exactly LATENCY+extra cycles after the acceptance cycle. With LATENCY=1 and extra=0, data_ok is in the cycle immediately after acceptance.
- DONE:
  - One cycle; dreq is ignored and addr_ok=0.
  - Go to IDLE.
  - This covers the initiator's registered valid deassertion.
- dresp.data holds the last response value until the next data_ok.
- The initiator keeps dreq stable from acceptance to data_ok. Changes to dreq in WAIT are ignored because the latched copy is used.
- Back-to-back: the minimum request spacing is LATENCY+2 cycles (accept, wait, DONE).
- init_ready = (state==IDLE) && !dreq.valid.
  - An init_we with init_ready=1 writes the full word at the next edge.
  - An init_we with init_ready=0 is dropped silently.
  - A simultaneous dreq.valid wins over init_we.
- Read-after-write to the same idx in consecutive requests returns the new data.
- A reset asserted while in WAIT drops data_ok and the pending operation. After release, the next accepted request behaves normally.

Decomposition:
- dbus_req_t, dbus_resp_t and msize_t stay in the common package.
- Add dbus_resp_state_t (IDLE/WAIT/DONE) to the pipes package next to mem_access_state_t.
- One sub-module, resp_mem: a DEPTH×64 array with byte-strobe write port, registered read port and backdoor full-word write port.
- The LFSR stays inline.

Test Plan:
1. LATENCY=2, RAND_LAT=0; preload word 5 = 64'h1122334455667788; read addr 0x28 → addr_ok in the accept cycle; data_ok 2 cycles later; dresp.data = 64'h1122334455667788; req_cnt=1.
2. Write addr 0x28, strobe 8'h0F, data 64'hAAAAAAAABBBBBBBB; then read 0x28 → 64'h11223344BBBBBBBB.
3. Address alias: with DEPTH=1024, write 0x2028 full strobe with 64'hDEAD; read 0x28 → 64'hDEAD.
4. RAND_LAT=1; issue 20 reads → every data_ok gap is in 2..5 cycles; no addr_ok in DONE; requests are spaced ≥ LATENCY+2 cycles.
5. Reset asserted in WAIT of a write of 64'hFF to word 7 (previously 0) → data_ok is never seen; after release, read word 7 returns 0; all outputs are 0 during reset.
6. Same-cycle init_we and dreq.valid in IDLE → init_ready=0; init write dropped; read served normally. init_we in WAIT → dropped, array unchanged.

Source files
------------

// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: bus request/response structs,
// responder FSM states and the LFSR step used for latency jitter.
package dbus_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_DONE = 2'd2
  } dbus_resp_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/dbus_responder_resp_mem.sv
// Backing store: DEPTH x 64-bit words, registered read, byte-strobe write
// port and a full-word backdoor write port (backdoor has priority).
module resp_mem #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_idx,
  output logic [63:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_strobe,
  input  logic [63:0]   wr_data,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_idx,
  input  logic [63:0]   bd_data
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rd_data_q;

  // Contents are intentionally never reset.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_idx];
    if (bd_we) begin
      mem_q[bd_idx] <= bd_data;
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_strobe[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dbus_responder.sv
// Memory-side data-bus responder: accepts one request at a time and answers
// after LATENCY (+0..3 LFSR jitter) cycles, then spends one DONE cycle.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter int          RAND_LAT  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  input  logic        init_we,
  input  logic [63:0] init_addr,
  input  logic [63:0] init_data,
  output logic        init_ready,
  output logic [31:0] req_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 3);

  dbus_resp_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      wdata_q, wdata_d;
  msize_t           size_q, size_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [31:0]      req_cnt_q, req_cnt_d;
  logic [63:0]      hold_q, hold_d;

  logic [AW-1:0] req_idx, rd_idx;
  logic [63:0]   rd_data;
  logic [1:0]    extra;
  logic          accept, fire;

  assign req_idx = dreq.addr[AW+2:3];
  assign accept  = (state_q == RS_IDLE) && dreq.valid;
  assign fire    = (state_q == RS_WAIT) && (cnt_q == '0);
  assign extra   = (RAND_LAT != 0) ? lfsr_q[1:0] : 2'b00;
  // Look up the incoming index while idle so a LATENCY=1 response has data.
  assign rd_idx  = (state_q == RS_IDLE) ? req_idx : idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RS_IDLE: if (dreq.valid) state_d = RS_WAIT;
      RS_WAIT: if (cnt_q == '0) state_d = RS_DONE;
      RS_DONE: state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  always_comb begin
    dresp.addr_ok = accept && reset;
    dresp.data_ok = fire;
    dresp.data    = fire ? rd_data : hold_q;
    init_ready    = (state_q == RS_IDLE) && !dreq.valid && reset;
  end

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    lfsr_d    = lfsr_q;
    req_cnt_d = req_cnt_q;
    hold_d    = hold_q;
    if (accept) begin
      idx_d    = req_idx;
      strobe_d = dreq.strobe;
      wdata_d  = dreq.data;
      size_d   = dreq.size;
      cnt_d    = CW'(LATENCY - 1) + CW'(extra);
      lfsr_d   = lfsr_step(lfsr_q);
    end else if (state_q == RS_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (fire) begin
      req_cnt_d = req_cnt_q + 32'd1;
      hold_d    = rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      size_q    <= MSIZE1;
      lfsr_q    <= LFSR_SEED;
      req_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      lfsr_q    <= lfsr_d;
      req_cnt_q <= req_cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign req_cnt = req_cnt_q;

  resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .wr_en     (fire && (strobe_q != 8'h00)),
    .wr_idx    (idx_q),
    .wr_strobe (strobe_q),
    .wr_data   (wdata_q),
    .bd_we     (init_we && init_ready),
    .bd_idx    (init_addr[AW+2:3]),
    .bd_data   (init_data)
  );

  logic unused_ok;
  assign unused_ok = ^{dreq.addr[63:AW+3], dreq.addr[2:0], size_q,
                       init_addr[63:AW+3], init_addr[2:0]};

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench: instance 0 fixed LATENCY=2, instance 1 with LFSR jitter.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq [2];
  dbus_resp_t  dresp [2];
  logic        init_we [2];
  logic [63:0] init_addr [2];
  logic [63:0] init_data [2];
  logic        init_ready [2];
  logic [31:0] req_cnt [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_responder #(.DEPTH(1024), .LATENCY(2), .RAND_LAT(0)) u_fix (
    .clk(clk), .reset(reset), .dreq(dreq[0]), .dresp(dresp[0]),
    .init_we(init_we[0]), .init_addr(init_addr[0]), .init_data(init_data[0]),
    .init_ready(init_ready[0]), .req_cnt(req_cnt[0])
  );

  dbus_responder #(.DEPTH(1024), .LATENCY(2), .RAND_LAT(1), .LFSR_SEED(16'hACE1)) u_rnd (
    .clk(clk), .reset(reset), .dreq(dreq[1]), .dresp(dresp[1]),
    .init_we(init_we[1]), .init_addr(init_addr[1]), .init_data(init_data[1]),
    .init_ready(init_ready[1]), .req_cnt(req_cnt[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; returns data, accept-to-data_ok cycles and
  // the accept cycle stamp. Leaves valid high on return (DUT back in IDLE).
  task automatic req(input int s, input logic [63:0] a, input logic [7:0] st,
                     input logic [63:0] d, input logic init_in_wait,
                     output logic [63:0] rdata, output int lat, output int acc);
    dreq[s] = '{valid: 1'b1, addr: a, size: MSIZE8, strobe: st, data: d};
    @(negedge clk);
    chk("addr_ok_accept", 64'(dresp[s].addr_ok), 64'd1);
    chk("init_ready_accept", 64'(init_ready[s]), 64'd0);
    acc   = cyc;
    lat   = 0;
    rdata = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      init_we[s]   = init_in_wait;
      init_addr[s] = a;
      init_data[s] = 64'h9999;
      lat++;
      @(negedge clk);
      if (init_in_wait) chk("init_ready_wait", 64'(init_ready[s]), 64'd0);
      chk("addr_ok_wait", 64'(dresp[s].addr_ok), 64'd0);
      if (dresp[s].data_ok) begin
        rdata = dresp[s].data;
        break;
      end
    end
    init_we[s] = 1'b0;
    chk("data_ok_seen", 64'(dresp[s].data_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("addr_ok_done", 64'(dresp[s].addr_ok), 64'd0);
    chk("data_ok_done", 64'(dresp[s].data_ok), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd;
    int          lat, acc, acc_prev, lat_prev, exp_lat;
    logic [15:0] lf;

    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      dreq[s]      = '0;
      init_we[s]   = 1'b0;
      init_addr[s] = '0;
      init_data[s] = '0;
    end
    dreq[0].valid = 1'b1;
    @(negedge clk);
    chk("rst_addr_ok", 64'(dresp[0].addr_ok), 64'd0);
    chk("rst_data_ok", 64'(dresp[0].data_ok), 64'd0);
    chk("rst_data", dresp[0].data, 64'd0);
    chk("rst_req_cnt", 64'(req_cnt[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    dreq[0].valid = 1'b0;

    // backdoor preload: word 5 and word 7
    init_we[0] = 1'b1; init_addr[0] = 64'h28; init_data[0] = 64'h1122334455667788;
    @(negedge clk);
    chk("init_ready_idle", 64'(init_ready[0]), 64'd1);
    @(posedge clk); #1;
    init_addr[0] = 64'h38; init_data[0] = 64'h0;
    @(posedge clk); #1;
    init_we[0] = 1'b0;

    req(0, 64'h28, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t1_data", rd, 64'h1122334455667788);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_req_cnt", 64'(req_cnt[0]), 64'd1);
    dreq[0].valid = 1'b0;
    @(posedge clk); #1;

    req(0, 64'h28, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, rd, lat, acc_prev);
    chk("t2_prewrite", rd, 64'h1122334455667788);
    req(0, 64'h28, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t2_rdata", rd, 64'h11223344BBBBBBBB);
    chk("t2_spacing", 64'(acc - acc_prev), 64'd4);

    req(0, 64'h2028, 8'hFF, 64'hDEAD, 1'b0, rd, lat, acc);
    req(0, 64'h28, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t3_alias", rd, 64'hDEAD);
    chk("t3_req_cnt", 64'(req_cnt[0]), 64'd5);
    dreq[0].valid = 1'b0;
    @(negedge clk);
    chk("hold_data", dresp[0].data, 64'hDEAD);
    chk("hold_init_ready", 64'(init_ready[0]), 64'd1);
    @(posedge clk); #1;

    // reset in the middle of a write's WAIT
    dreq[0] = '{valid: 1'b1, addr: 64'h38, size: MSIZE8, strobe: 8'hFF, data: 64'hFF};
    @(negedge clk);
    chk("t5_accept", 64'(dresp[0].addr_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_wait_quiet", 64'(dresp[0].data_ok), 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_addr_ok", 64'(dresp[0].addr_ok), 64'd0);
    chk("t5_rst_data", dresp[0].data, 64'd0);
    chk("t5_rst_req_cnt", 64'(req_cnt[0]), 64'd0);
    chk("t5_rst_init_ready", 64'(init_ready[0]), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_data_ok", 64'(dresp[0].data_ok), 64'd0);
    end
    dreq[0].valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req(0, 64'h38, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t5_word7", rd, 64'h0);
    chk("t5_req_cnt", 64'(req_cnt[0]), 64'd1);
    chk("t5_lat", 64'(lat), 64'd2);

    // init_we colliding with a request, then during WAIT
    init_we[0] = 1'b1; init_addr[0] = 64'h28; init_data[0] = 64'h1234;
    req(0, 64'h28, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t6_collide_read", rd, 64'hDEAD);
    req(0, 64'h28, 8'h00, 64'h0, 1'b1, rd, lat, acc);
    chk("t6_wait_read", rd, 64'hDEAD);
    req(0, 64'h28, 8'h00, 64'h0, 1'b0, rd, lat, acc);
    chk("t6_unchanged", rd, 64'hDEAD);
    dreq[0].valid = 1'b0;

    // jittered latency, back-to-back requests
    lf       = 16'hACE1;
    acc_prev = 0;
    lat_prev = 0;
    for (int i = 0; i < 20; i++) begin
      exp_lat = 2 + int'(lf[1:0]);
      req(1, 64'(i * 8), 8'h00, 64'h0, 1'b0, rd, lat, acc);
      chk("t4_lat", 64'(lat), 64'(exp_lat));
      chk("t4_lat_range", 64'(lat >= 2 && lat <= 5), 64'd1);
      if (i > 0) begin
        chk("t4_spacing", 64'(acc - acc_prev), 64'(lat_prev + 2));
        chk("t4_spacing_min", 64'((acc - acc_prev) >= 4), 64'd1);
      end
      acc_prev = acc;
      lat_prev = lat;
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    chk("t4_req_cnt", 64'(req_cnt[1]), 64'd20);
    dreq[1].valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
